// File: rtl/adc_mon_pkg.sv
// Shared types and arithmetic helpers for the ADC saturation monitor.
// Helpers work on 64-bit operands so a single function serves every counter width.
package adc_mon_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } mon_state_t;

  // Add a 0/1 increment, clamping at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] a, input logic inc,
                                          input int unsigned w);
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (inc && (a < lim)) return a + 64'd1;
    return a;
  endfunction

  function automatic logic sat_hit(input logic signed [63:0] x,
                                   input logic signed [63:0] hi,
                                   input logic signed [63:0] lo);
    return (x >= hi) || (x <= lo);
  endfunction

endpackage

// File: rtl/adc_sat_chan.sv
// One channel of the saturation monitor: registered sat flag, per-chirp
// accumulator, per-CPI max and bad-chirp counter, and sticky status bit.
module adc_sat_chan
  import adc_mon_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32,
  parameter int BAD_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_sample,
  input  logic [DATA_W-1:0] i_sat_hi,
  input  logic [DATA_W-1:0] i_sat_lo,
  input  logic [CNT_W-1:0]  i_chirp_thr,
  input  logic              i_start,
  input  logic              i_accum,
  input  logic              i_finish,
  input  logic              i_cpi_clr,
  input  logic              i_irq_clr,
  output logic [CNT_W-1:0]  o_chirp_cnt,
  output logic [CNT_W-1:0]  o_chirp_cnt_max,
  output logic [BAD_W-1:0]  o_bad_chirps,
  output logic              o_irq_status
);

  logic signed [DATA_W-1:0] w_x, w_hi, w_lo;
  logic                     w_hit, w_over;
  logic [CNT_W-1:0]         w_base, w_final, w_max_next;
  logic [BAD_W-1:0]         w_bad_next;

  logic                     r_flag;
  logic [CNT_W-1:0]         r_acc, r_cnt, r_max;
  logic [BAD_W-1:0]         r_bad;
  logic                     r_irq;

  assign w_x   = i_sample;
  assign w_hi  = i_sat_hi;
  assign w_lo  = i_sat_lo;
  assign w_hit = sat_hit(64'(w_x), 64'(w_hi), 64'(w_lo));

  // A sop beat restarts from zero even if a partial chirp was in progress.
  assign w_base     = i_start ? '0 : r_acc;
  assign w_final    = CNT_W'(sat_inc(64'(w_base), r_flag, CNT_W));
  assign w_over     = (w_final > i_chirp_thr);
  assign w_max_next = (i_cpi_clr || (w_final > r_max)) ? w_final : r_max;
  assign w_bad_next = i_cpi_clr ? BAD_W'(w_over)
                                : BAD_W'(sat_inc(64'(r_bad), w_over, BAD_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag <= 1'b0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_max  <= '0;
      r_bad  <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_flag <= w_hit;
      if (i_finish) begin
        r_acc <= '0;
        r_cnt <= w_final;
        r_max <= w_max_next;
        r_bad <= w_bad_next;
      end else begin
        if (i_start)      r_acc <= CNT_W'(r_flag);
        else if (i_accum) r_acc <= CNT_W'(sat_inc(64'(r_acc), r_flag, CNT_W));
        if (i_cpi_clr) begin
          r_max <= '0;
          r_bad <= '0;
        end
      end
      // Set has priority over a same-cycle clear.
      if (i_finish && w_over) r_irq <= 1'b1;
      else if (i_irq_clr)     r_irq <= 1'b0;
    end
  end

  assign o_chirp_cnt     = r_cnt;
  assign o_chirp_cnt_max = r_max;
  assign o_bad_chirps    = r_bad;
  assign o_irq_status    = r_irq;

endmodule

// File: rtl/adc_sat_monitor.sv
// Multi-channel ADC saturation monitor on the packed chirp stream: input
// register, shared chirp framing FSM, event strobes and per-channel units.
module adc_sat_monitor
  import adc_mon_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32,
  parameter int BAD_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  input  logic                     s_sop,
  input  logic                     s_eop,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  input  logic                     cpi_start,
  input  logic [DATA_W-1:0]        cfg_sat_hi,
  input  logic [DATA_W-1:0]        cfg_sat_lo,
  input  logic [CNT_W-1:0]         cfg_chirp_thr,
  input  logic [NUM_CH-1:0]        cfg_irq_en,
  input  logic [NUM_CH-1:0]        irq_clr,
  output logic [NUM_CH*CNT_W-1:0]  chirp_cnt,
  output logic [NUM_CH*CNT_W-1:0]  chirp_cnt_max,
  output logic [NUM_CH*BAD_W-1:0]  cpi_bad_chirps,
  output logic                     result_valid,
  output logic [NUM_CH-1:0]        irq_status,
  output logic                     irq,
  output logic                     seq_err
);

  logic       r_valid, r_sop, r_eop, r_cpi;
  mon_state_t r_state;
  logic       r_result_valid, r_seq_err;

  logic       w_active, w_start, w_accum, w_finish, w_seq_err;

  assign w_active  = (r_state == ST_ACTIVE);
  assign w_start   = r_valid & r_sop;
  assign w_finish  = r_valid & r_eop & (r_sop | w_active);
  assign w_accum   = r_valid & ~r_sop & ~r_eop & w_active;
  // Either a sop that truncates a running chirp, or an orphan eop.
  assign w_seq_err = r_valid & ((r_sop & w_active) | (r_eop & ~r_sop & ~w_active));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid        <= 1'b0;
      r_sop          <= 1'b0;
      r_eop          <= 1'b0;
      r_cpi          <= 1'b0;
      r_state        <= ST_IDLE;
      r_result_valid <= 1'b0;
      r_seq_err      <= 1'b0;
    end else begin
      r_valid        <= s_valid;
      r_sop          <= s_sop;
      r_eop          <= s_eop;
      r_cpi          <= cpi_start;
      r_result_valid <= w_finish;
      r_seq_err      <= w_seq_err;
      if (r_valid) begin
        if (r_sop && !r_eop) r_state <= ST_ACTIVE;
        else if (r_eop)      r_state <= ST_IDLE;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      adc_sat_chan #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W),
        .BAD_W (BAD_W)
      ) u_chan (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_sample       (s_data[gi*DATA_W +: DATA_W]),
        .i_sat_hi       (cfg_sat_hi),
        .i_sat_lo       (cfg_sat_lo),
        .i_chirp_thr    (cfg_chirp_thr),
        .i_start        (w_start),
        .i_accum        (w_accum),
        .i_finish       (w_finish),
        .i_cpi_clr      (r_cpi),
        .i_irq_clr      (irq_clr[gi]),
        .o_chirp_cnt    (chirp_cnt[gi*CNT_W +: CNT_W]),
        .o_chirp_cnt_max(chirp_cnt_max[gi*CNT_W +: CNT_W]),
        .o_bad_chirps   (cpi_bad_chirps[gi*BAD_W +: BAD_W]),
        .o_irq_status   (irq_status[gi])
      );
    end
  endgenerate

  assign result_valid = r_result_valid;
  assign seq_err      = r_seq_err;
  assign irq          = |(irq_status & cfg_irq_en);

endmodule

// File: tb/tb_adc_sat_monitor.sv
// Randomised and directed bench for adc_sat_monitor; two instances (32-bit
// and 4-bit counters) share stimulus and are checked against a chirp-level model.
module tb_adc_sat_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0, s_sop = 1'b0, s_eop = 1'b0, cpi_start = 1'b0;
  logic [31:0] s_data = '0;
  logic [15:0] cfg_sat_hi = 16'h7FFF, cfg_sat_lo = 16'h8001;
  logic [31:0] cfg_chirp_thr = 32'd15;
  logic [1:0]  cfg_irq_en = 2'b11, irq_clr = 2'b00;

  logic [63:0] a_cnt, a_max;
  logic [31:0] a_bad;
  logic        a_rv, a_irq, a_se;
  logic [1:0]  a_st;
  logic [7:0]  b_cnt, b_max;
  logic [3:0]  b_bad;
  logic        b_rv, b_irq, b_se;
  logic [1:0]  b_st;

  always #5 clk = ~clk;

  adc_sat_monitor #(.NUM_CH(2), .DATA_W(16), .CNT_W(32), .BAD_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop),
    .s_data(s_data), .cpi_start(cpi_start), .cfg_sat_hi(cfg_sat_hi),
    .cfg_sat_lo(cfg_sat_lo), .cfg_chirp_thr(cfg_chirp_thr), .cfg_irq_en(cfg_irq_en),
    .irq_clr(irq_clr), .chirp_cnt(a_cnt), .chirp_cnt_max(a_max),
    .cpi_bad_chirps(a_bad), .result_valid(a_rv), .irq_status(a_st), .irq(a_irq),
    .seq_err(a_se));

  adc_sat_monitor #(.NUM_CH(2), .DATA_W(16), .CNT_W(4), .BAD_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop),
    .s_data(s_data), .cpi_start(cpi_start), .cfg_sat_hi(cfg_sat_hi),
    .cfg_sat_lo(cfg_sat_lo), .cfg_chirp_thr(cfg_chirp_thr[3:0]), .cfg_irq_en(cfg_irq_en),
    .irq_clr(irq_clr), .chirp_cnt(b_cnt), .chirp_cnt_max(b_max),
    .cpi_bad_chirps(b_bad), .result_valid(b_rv), .irq_status(b_st), .irq(b_irq),
    .seq_err(b_se));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: chirp-level bookkeeping. Index [d] selects 32-bit (0) / 4-bit (1) instance.
  typedef struct { bit v; bit s; bit e; bit cpi; bit [1:0] f; } beat_t;
  beat_t  pend;
  bit     m_active;
  longint m_acc  [2];
  longint e_cnt  [2][2];
  longint e_max  [2][2];
  longint e_bad  [2][2];
  bit [1:0] e_st [2];
  bit     e_rv, e_se;
  longint cmax   [2];
  longint bmax   [2];

  function automatic bit is_sat(input logic [15:0] d);
    return ($signed(d) >= $signed(cfg_sat_hi)) || ($signed(d) <= $signed(cfg_sat_lo));
  endfunction

  task automatic model_reset();
    pend = '{0, 0, 0, 0, 2'b00};
    m_active = 0;
    for (int d = 0; d < 2; d++) begin
      e_st[d] = 2'b00;
      for (int c = 0; c < 2; c++) begin
        e_cnt[d][c] = 0; e_max[d][c] = 0; e_bad[d][c] = 0;
      end
    end
    m_acc[0] = 0; m_acc[1] = 0;
    e_rv = 0; e_se = 0;
  endtask

  // Effects of the previously presented beat, landing at this cycle's edge.
  task automatic apply_pend(input longint thr, input bit [1:0] clr);
    bit fin, se, over;
    longint fv;
    fin = 0; se = 0;
    if (pend.v) begin
      if (pend.s) begin
        se = m_active;
        for (int c = 0; c < 2; c++) m_acc[c] = pend.f[c];
        if (pend.e) begin fin = 1; m_active = 0; end else m_active = 1;
      end else if (m_active) begin
        for (int c = 0; c < 2; c++) m_acc[c] += pend.f[c];
        if (pend.e) begin fin = 1; m_active = 0; end
      end else if (pend.e) begin
        se = 1;
      end
    end
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        over = 0;
        if (fin) begin
          fv = (m_acc[c] > cmax[d]) ? cmax[d] : m_acc[c];
          over = (fv > thr);
          e_cnt[d][c] = fv;
          if (pend.cpi) begin
            e_max[d][c] = fv;
            e_bad[d][c] = over;
          end else begin
            if (fv > e_max[d][c]) e_max[d][c] = fv;
            if (e_bad[d][c] + over <= bmax[d]) e_bad[d][c] = e_bad[d][c] + over;
          end
        end else if (pend.cpi) begin
          e_max[d][c] = 0;
          e_bad[d][c] = 0;
        end
        if (over) e_st[d][c] = 1'b1;
        else if (clr[c]) e_st[d][c] = 1'b0;
      end
    end
    e_rv = fin;
    e_se = se;
  endtask

  task automatic check_all();
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("cnt32[%0d]", c), 64'(a_cnt[c*32 +: 32]), e_cnt[0][c]);
      chk($sformatf("max32[%0d]", c), 64'(a_max[c*32 +: 32]), e_max[0][c]);
      chk($sformatf("bad16[%0d]", c), 64'(a_bad[c*16 +: 16]), e_bad[0][c]);
      chk($sformatf("cnt4[%0d]", c),  64'(b_cnt[c*4 +: 4]),   e_cnt[1][c]);
      chk($sformatf("max4[%0d]", c),  64'(b_max[c*4 +: 4]),   e_max[1][c]);
      chk($sformatf("bad2[%0d]", c),  64'(b_bad[c*2 +: 2]),   e_bad[1][c]);
    end
    chk("status32", 64'(a_st), 64'(e_st[0]));
    chk("status4",  64'(b_st), 64'(e_st[1]));
    chk("irq32", 64'(a_irq), 64'(|(e_st[0] & cfg_irq_en)));
    chk("irq4",  64'(b_irq), 64'(|(e_st[1] & cfg_irq_en)));
    chk("rv32", 64'(a_rv), 64'(e_rv));
    chk("rv4",  64'(b_rv), 64'(e_rv));
    chk("seq32", 64'(a_se), 64'(e_se));
    chk("seq4",  64'(b_se), 64'(e_se));
  endtask

  task automatic cyc(input bit v, input bit s, input bit e, input logic [15:0] d0,
                     input logic [15:0] d1, input bit cpi, input logic [1:0] clr);
    @(negedge clk);
    s_valid = v; s_sop = s; s_eop = e; s_data = {d1, d0}; cpi_start = cpi; irq_clr = clr;
    apply_pend(longint'(cfg_chirp_thr), clr);
    pend.v = v; pend.s = s; pend.e = e; pend.cpi = cpi;
    pend.f = {is_sat(d1), is_sat(d0)};
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic logic [15:0] quiet();
    return 16'(int'($urandom_range(0, 2000)) - 1000);
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, quiet(), quiet(), 0, 2'b00);
  endtask

  // Chirp of len beats; first n0 (n1) beats saturated on ch0 (ch1).
  task automatic chirp(input int len, input int n0, input int n1, input bit cpi_eop);
    for (int i = 0; i < len; i++)
      cyc(1, i == 0, i == len - 1, (i < n0) ? 16'h7FFF : quiet(),
          (i < n1) ? 16'h8000 : quiet(), cpi_eop && (i == len - 1), 2'b00);
  endtask

  initial begin
    cmax[0] = 64'hFFFF_FFFF; cmax[1] = 15;
    bmax[0] = 65535;         bmax[1] = 3;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // 8-beat chirp: ch0 saturated at beats 2 and 5, ch1 at beat 7.
    for (int i = 0; i < 8; i++)
      cyc(1, i == 0, i == 7, (i == 2 || i == 5) ? 16'h7FFF : quiet(),
          (i == 7) ? 16'h8000 : quiet(), 0, 2'b00);
    idle(3);

    // Three chirps 3/9/4 on ch0 with thr 5, then new CPI and W1C.
    cfg_chirp_thr = 32'd5;
    cyc(0, 0, 0, quiet(), quiet(), 1, 2'b00);
    chirp(12, 3, 0, 0);
    chirp(12, 9, 0, 0);
    chirp(12, 4, 0, 0);
    idle(2);
    cyc(0, 0, 0, quiet(), quiet(), 1, 2'b00);
    idle(3);
    cyc(0, 0, 0, quiet(), quiet(), 0, 2'b01);
    idle(2);

    // sop mid-chirp after 4 saturated beats, then 2 saturated beats.
    cyc(1, 1, 0, 16'h7FFF, 16'h8000, 0, 2'b00);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 16'h7FFF, 16'h8000, 0, 2'b00);
    cyc(1, 1, 0, 16'h7FFF, quiet(), 0, 2'b00);
    cyc(1, 0, 0, 16'h7FFF, quiet(), 0, 2'b00);
    cyc(1, 0, 1, quiet(), quiet(), 0, 2'b00);
    idle(3);

    // cpi_start coinciding with eop: prior max 20, new chirp count 6.
    cyc(0, 0, 0, quiet(), quiet(), 1, 2'b00);
    chirp(25, 20, 0, 0);
    chirp(10, 6, 0, 1);
    idle(3);

    // 20 saturated beats saturate the 4-bit counters; then set-beats-clear.
    chirp(22, 20, 20, 0);
    idle(2);
    cyc(0, 0, 0, quiet(), quiet(), 0, 2'b11);
    chirp(8, 7, 0, 0);
    cyc(0, 0, 0, quiet(), quiet(), 0, 2'b11);
    idle(2);

    // Asynchronous reset mid-chirp, then an orphan eop.
    chirp(3, 3, 3, 0);
    cyc(1, 1, 0, 16'h7FFF, 16'h8000, 0, 2'b00);
    cyc(1, 0, 0, 16'h7FFF, 16'h8000, 0, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    s_valid = 0; s_sop = 0; s_eop = 0; cpi_start = 0; irq_clr = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 1, 16'h7FFF, 16'h8000, 0, 2'b00);
    idle(3);

    // Random traffic with drifting configuration.
    for (int n = 0; n < 2500; n++) begin
      logic [15:0] d0, d1;
      if ($urandom_range(0, 99) < 3) begin
        cfg_sat_hi = 16'($urandom_range(0, 32767));
        cfg_sat_lo = 16'(-int'($urandom_range(0, 32768)));
      end
      if ($urandom_range(0, 99) < 5) cfg_chirp_thr = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 5) cfg_irq_en = 2'($urandom_range(0, 3));
      d0 = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
      d1 = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
          d0, d1, $urandom_range(0, 99) < 3,
          ($urandom_range(0, 99) < 5) ? 2'($urandom_range(1, 3)) : 2'b00);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_sat_monitor.md
# adc_sat_monitor

Parametrised, multi-channel ADC saturation monitor placed after the per-channel ADC packers, on the packed chirp stream (sop/eop/valid framing). Per chirp, it counts samples at or beyond programmable signed high/low limits for every channel and tracks the true per-CPI maximum and the number of over-threshold chirps. It raises sticky per-channel interrupt bits with enable mask and write-1-to-clear. Replaces the fixed two-channel, full-scale-only, non-sticky saturation check.

## Interface
- NUM_CH, 2, number of ADC channels (1..8)
- DATA_W, 16, sample width, signed two's complement
- CNT_W, 32, per-chirp counter width
- BAD_W, 16, per-CPI over-threshold chirp counter width

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous assert, active-low
- s_valid  in  1  beat valid, shared by all channels
- s_sop  in  1  first beat of chirp (qualified by s_valid)
- s_eop  in  1  last beat of chirp (qualified by s_valid)
- s_data  in  NUM_CH*DATA_W  channel c at [c*DATA_W +: DATA_W]
- cpi_start  in  1  one-cycle pulse, CPI boundary
- cfg_sat_hi  in  DATA_W  signed upper limit, quasi-static
- cfg_sat_lo  in  DATA_W  signed lower limit, quasi-static
- cfg_chirp_thr  in  CNT_W  per-chirp count threshold
- cfg_irq_en  in  NUM_CH  interrupt enable per channel
- irq_clr  in  NUM_CH  W1C pulse per status bit
- chirp_cnt  out  NUM_CH*CNT_W  saturated-sample count of last completed chirp
- chirp_cnt_max  out  NUM_CH*CNT_W  max chirp_cnt in current CPI
- cpi_bad_chirps  out  NUM_CH*BAD_W  chirps in current CPI with count > cfg_chirp_thr
- result_valid  out  1  one-cycle pulse, chirp results updated
- irq_status  out  NUM_CH  sticky over-threshold flags
- irq  out  1  |(irq_status & cfg_irq_en)
- seq_err  out  1  one-cycle pulse, framing violation

## Operation
- Stage 1: s_valid, s_sop, s_eop, s_data, cpi_start registered; per-channel sat flag = (x >= cfg_sat_hi) || (x <= cfg_sat_lo), signed compare.
- FSM, shared: IDLE, ACTIVE. IDLE + valid sop -> ACTIVE (sop&eop same beat: single-beat chirp, stays IDLE). ACTIVE + valid eop -> IDLE.
- Accumulator per channel: on sop, acc <= flag; ACTIVE non-eop valid beat, acc <= acc + flag; valid low holds acc; counting saturates at all-ones, never wraps.
- On eop (from ACTIVE or sop&eop): final = sat-add(acc or 0, flag); chirp_cnt <= final; chirp_cnt_max <= max(chirp_cnt_max, final); if final > cfg_chirp_thr: cpi_bad_chirps += 1 (saturating) and irq_status[c] <= 1; result_valid pulses.
- Framing errors, seq_err pulse: sop while ACTIVE -> discard partial acc, restart from this beat; eop in IDLE without sop -> beat ignored, no results. Valid non-sop beats in IDLE ignored silently.
- cpi_start clears chirp_cnt_max and cpi_bad_chirps. If its stage-1 copy coincides with an eop update, the new values come from that chirp alone: max = final, bad = (final > thr).
- irq_clr[c] clears irq_status[c]; a simultaneous set wins.
- Reset: all outputs, accumulators, pipeline regs 0; FSM IDLE.

## Timing
- Beat presented at cycle k: sampled at edge k, accumulated at edge k+1.
- Eop beat at cycle k: chirp_cnt, chirp_cnt_max, cpi_bad_chirps, irq_status, result_valid all updated at edge k+1, latency 2 edges. irq combinational from registered irq_status.
- cpi_start at cycle k: takes effect at edge k+1, aligned with data presented at cycle k.
- irq_clr: unregistered, clears at the next edge.
- Throughput: one beat per cycle, no backpressure. Back-to-back chirps with eop at k and sop at k+1 need no gap.
- Config inputs sampled every cycle. A change mid-chirp affects following beats only.
- rst_n asserted mid-chirp: immediate clear. Next chirp requires a fresh sop.

## Structure
- Package adc_mon_pkg: FSM state encodings (IDLE=0, ACTIVE=1) and the saturating-add and signed-compare functions.
- Sub-module adc_sat_chan, generated NUM_CH times: flag compare, accumulator, max, bad-chirp counter, status bit.
- Top holds the input register, shared FSM and event strobes (start, accumulate, finish, cpi_clr), seq_err and the irq OR.

## Test plan
- NUM_CH=2, limits ±32767. 8-beat chirp, ch0 samples 7FFF at beats 2,5, ch1 8000 at beat 7 -> chirp_cnt {1,2}, result_valid 2 edges after eop.
- Three chirps, ch0 counts 3, 9, 4, thr=5 -> max 9, cpi_bad_chirps 1, irq_status[0]=1. Then cpi_start -> max 0 and bad 0; irq_status stays 1 until irq_clr[0].
- sop mid-chirp after 4 saturated beats -> seq_err pulse; next eop reports only the post-restart count.
- cpi_start in the same cycle as an eop with count 6, prior max 20 -> chirp_cnt_max=6, cpi_bad_chirps=1 (thr=5).
- CNT_W=4, 20 saturated beats -> chirp_cnt=15, no wrap. irq_clr with a simultaneous set -> irq_status stays 1.
- rst_n low mid-chirp -> all outputs 0 asynchronously. Eop without sop after release -> seq_err, no result_valid.
